// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } imem_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned WAIT_W    = 4;

endpackage

// File: rtl/imem_array.sv
// Instruction word store: one preload write port, one synchronous read port, no reset.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_index,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_index,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  // Both ports update with non-blocking assignments, so a same-edge write
  // to the read index is seen only by later reads (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_index];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch-side instruction memory responder: accepts a PC, waits WAIT_CYCLES, returns the word with fault flags.
module imem_responder
  import imem_pkg::*;
#(
  parameter logic [31:0] PC_START    = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  input  logic                           flush,
  output logic                           stall,
  output logic                           resp_valid,
  output logic [31:0]                    resp_instr,
  output logic                           resp_misaligned,
  output logic                           resp_access_fault,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_index,
  input  logic [31:0]                    ld_data
);

  localparam int unsigned       AW        = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  imem_state_t       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q;
  logic [AW-1:0]     index_q;
  logic              mis_q, af_q, instr_sel_q;

  logic              accept;
  logic [31:0]       req_off;
  logic              req_mis, req_af;
  logic [AW-1:0]     req_index;

  logic              rd_en, rd_fault;
  logic [AW-1:0]     rd_index;
  logic [31:0]       rd_data;

  // Offset wraps modulo 2^32, so PCs below PC_START decode as far out of range.
  always_comb begin
    req_off   = req_addr - PC_START;
    req_mis   = |req_off[1:0];
    req_af    = {2'b00, req_off[31:2]} >= DEPTH_WORDS;
    req_index = req_off[AW+1:2];
  end

  assign accept = (state_q == IDLE) && req_valid && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid) state_d = (WAIT_CYCLES == 0) ? RESP : BUSY;
        BUSY:    if (cnt_q <= WAIT_W'(1)) state_d = RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // With WAIT_CYCLES == 0 the read happens on the accept edge, so the read
  // port takes the live request decode in IDLE and the latched one in BUSY.
  always_comb begin
    if (state_q == IDLE) begin
      rd_index = req_index;
      rd_fault = req_mis | req_af;
    end else begin
      rd_index = index_q;
      rd_fault = mis_q | af_q;
    end
    rd_en = (state_d == RESP) && !rd_fault;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      index_q     <= '0;
      mis_q       <= 1'b0;
      af_q        <= 1'b0;
      instr_sel_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= WAIT_INIT;
        index_q <= req_index;
        mis_q   <= req_mis;
        af_q    <= req_af;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - WAIT_W'(1);
      end
      if (state_d == RESP) begin
        instr_sel_q <= !rd_fault;
      end else if (accept) begin
        instr_sel_q <= 1'b0;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk      (clk),
    .wr_en    (ld_en),
    .wr_index (ld_index),
    .wr_data  (ld_data),
    .rd_en    (rd_en),
    .rd_index (rd_index),
    .rd_data  (rd_data)
  );

  always_comb begin
    stall = 1'b0;
    if (!reset && !flush) begin
      case (state_q)
        IDLE:    stall = req_valid;
        BUSY:    stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
    resp_valid        = (state_q == RESP) && !flush;
    resp_instr        = instr_sel_q ? rd_data : INSTR_NOP;
    resp_misaligned   = mis_q;
    resp_access_fault = af_q;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: three responders (WAIT_CYCLES 0, 1, 3) driven by directed and random fetches.
module tb_imem_responder;

  localparam logic [31:0] PC0   = 32'h8000_0000;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int          NI    = 3;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  function automatic int unsigned wait_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid   [NI];
  logic [31:0]   req_addr    [NI];
  logic          flush       [NI];
  logic          stall       [NI];
  logic          resp_valid  [NI];
  logic [31:0]   resp_instr  [NI];
  logic          resp_mis    [NI];
  logic          resp_af     [NI];
  logic          ld_en;
  logic [AW-1:0] ld_index;
  logic [31:0]   ld_data;

  logic [31:0]   mem_model [DEPTH];
  int            checks = 0;
  int            errors = 0;

  int            ri, rf;
  logic [31:0]   ra, rn;
  bit            rc;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    imem_responder #(
      .PC_START    (PC0),
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk               (clk),
      .reset             (reset),
      .req_valid         (req_valid[g]),
      .req_addr          (req_addr[g]),
      .flush             (flush[g]),
      .stall             (stall[g]),
      .resp_valid        (resp_valid[g]),
      .resp_instr        (resp_instr[g]),
      .resp_misaligned   (resp_mis[g]),
      .resp_access_fault (resp_af[g]),
      .ld_en             (ld_en),
      .ld_index          (ld_index),
      .ld_data           (ld_data)
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input int unsigned idx, input logic [31:0] d);
    @(negedge clk);
    ld_en    = 1'b1;
    ld_index = AW'(idx);
    ld_data  = d;
    mem_model[idx] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check_eq($sformatf("%s_i%0d_stall", tag, i), 32'(stall[i]), 0);
    check_eq($sformatf("%s_i%0d_rvalid", tag, i), 32'(resp_valid[i]), 0);
    check_eq($sformatf("%s_i%0d_instr", tag, i), resp_instr[i], NOP);
    check_eq($sformatf("%s_i%0d_mis", tag, i), 32'(resp_mis[i]), 0);
    check_eq($sformatf("%s_i%0d_af", tag, i), 32'(resp_af[i]), 0);
  endtask

  // One fetch on responder i. Expectations come from address arithmetic and the
  // word-array model: stall for the request cycle plus WAIT cycles, then one response.
  // flush_at (>=0) raises flush in that cycle of the transaction; chain keeps
  // req_valid up with next_a during the response cycle, as a fetch stage would.
  task automatic fetch(input int i, input logic [31:0] a, input int flush_at,
                       input bit chain, input logic [31:0] next_a);
    int          w;
    logic [31:0] off, e_instr;
    logic        e_mis, e_af;
    bit          done;
    w       = int'(wait_of(i));
    off     = a - PC0;
    e_mis   = (off % 4) != 0;
    e_af    = off >= 32'(4 * DEPTH);
    e_instr = NOP;
    if (!e_mis && !e_af) e_instr = mem_model[off / 4];
    done = 1'b0;
    for (int c = 0; c <= w + 1 && !done; c++) begin
      @(negedge clk);
      req_addr[i] = a;
      if (c == flush_at) begin
        req_valid[i] = 1'b1;
        flush[i]     = 1'b1;
        #1;
        check_eq($sformatf("flush_i%0d_c%0d_stall", i, c), 32'(stall[i]), 0);
        check_eq($sformatf("flush_i%0d_c%0d_rvalid", i, c), 32'(resp_valid[i]), 0);
        @(negedge clk);
        req_valid[i] = 1'b0;
        flush[i]     = 1'b0;
        #1;
        check_eq($sformatf("postflush_i%0d_stall", i), 32'(stall[i]), 0);
        check_eq($sformatf("postflush_i%0d_rvalid", i), 32'(resp_valid[i]), 0);
        done = 1'b1;
      end else if (c <= w) begin
        req_valid[i] = 1'b1;
        #1;
        check_eq($sformatf("wait_i%0d_c%0d_stall", i, c), 32'(stall[i]), 1);
        check_eq($sformatf("wait_i%0d_c%0d_rvalid", i, c), 32'(resp_valid[i]), 0);
      end else begin
        req_valid[i] = chain;
        req_addr[i]  = chain ? next_a : a;
        #1;
        check_eq($sformatf("resp_i%0d_%h_rvalid", i, a), 32'(resp_valid[i]), 1);
        check_eq($sformatf("resp_i%0d_%h_stall", i, a), 32'(stall[i]), 0);
        check_eq($sformatf("resp_i%0d_%h_instr", i, a), resp_instr[i], e_instr);
        check_eq($sformatf("resp_i%0d_%h_mis", i, a), 32'(resp_mis[i]), 32'(e_mis));
        check_eq($sformatf("resp_i%0d_%h_af", i, a), 32'(resp_af[i]), 32'(e_af));
      end
    end
  endtask

  function automatic logic [31:0] gen_addr();
    int unsigned k, idx;
    k   = $urandom_range(0, 5);
    idx = $urandom_range(0, 15);
    case (k)
      0, 1:    return PC0 + 4 * idx;
      2:       return PC0 + 4 * idx + $urandom_range(1, 3);
      3:       return PC0 - 4 * $urandom_range(1, 8);
      4:       return PC0 + 4 * (DEPTH + $urandom_range(0, 8));
      default: return PC0 + 4 * (DEPTH - 1);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    ld_en    = 1'b0;
    ld_index = '0;
    ld_data  = '0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_addr[i]  = '0;
      flush[i]     = 1'b0;
    end
    repeat (2) @(negedge clk);
    req_valid[0] = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check_reset_outputs(i, "por");
    req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    load(0, 32'h0010_0093);
    for (int unsigned k = 1; k < 16; k++) load(k, $urandom);
    load(DEPTH - 1, $urandom);

    fetch(1, PC0, -1, 1'b0, '0);

    fetch(0, PC0,     -1, 1'b1, PC0 + 4);
    fetch(0, PC0 + 4, -1, 1'b1, PC0 + 8);
    fetch(0, PC0 + 8, -1, 1'b0, '0);

    fetch(1, PC0 + 2,                 -1, 1'b0, '0);
    fetch(1, 32'h7FFF_FFFC,           -1, 1'b0, '0);
    fetch(1, PC0 + 4 * DEPTH,         -1, 1'b0, '0);
    fetch(1, PC0 + 4 * (DEPTH - 1),   -1, 1'b0, '0);
    fetch(0, PC0 + 4 * DEPTH + 1,     -1, 1'b0, '0);

    fetch(2, PC0 + 4, 2, 1'b0, '0);
    fetch(2, PC0 + 8, -1, 1'b0, '0);
    fetch(2, PC0 + 12, 4, 1'b0, '0);
    fetch(1, PC0 + 16, 0, 1'b0, '0);
    fetch(0, PC0 + 20, 1, 1'b0, '0);
    fetch(1, PC0 + 16, -1, 1'b0, '0);

    // Asynchronous reset while responder 2 is busy with a misaligned fetch.
    @(negedge clk);
    req_valid[2] = 1'b1;
    req_addr[2]  = PC0 + 1;
    #1;
    check_eq("rstbusy_accept_stall", 32'(stall[2]), 1);
    @(negedge clk);
    #1;
    check_eq("rstbusy_busy_stall", 32'(stall[2]), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs(2, "rstbusy");
    req_valid[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    fetch(2, PC0 + 12, -1, 1'b0, '0);
    fetch(1, PC0,      -1, 1'b0, '0);

    // Preload write to index 5 on the edge that enters RESP for a read of index 5.
    fork
      fetch(1, PC0 + 20, -1, 1'b0, '0);
      begin
        @(negedge clk);
        @(negedge clk);
        ld_en    = 1'b1;
        ld_index = AW'(5);
        ld_data  = 32'hCAFE_0005;
        @(negedge clk);
        ld_en = 1'b0;
      end
    join
    mem_model[5] = 32'hCAFE_0005;
    fetch(1, PC0 + 20, -1, 1'b0, '0);

    ri = $urandom_range(0, NI - 1);
    ra = gen_addr();
    for (int n = 0; n < 60; n++) begin
      rn = gen_addr();
      rc = 1'($urandom_range(0, 1));
      rf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, wait_of(ri) + 1)) : -1;
      if (rf >= 0 || n == 59) rc = 1'b0;
      fetch(ri, ra, rf, rc, rn);
      if (rc) begin
        ra = rn;
      end else begin
        ri = $urandom_range(0, NI - 1);
        ra = gen_addr();
      end
    end

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
